dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port data memory (combinational read, write on rising `clk` when its write enable is high) between the CPU load/store path (port 0) and a loader/debug master (port 1). It sits between the requesters and the data memory and drives the memory's write enable, address and write data. Each port may lock the memory for a bounded burst. Read data is returned through a registered response.

## Interface
- `ADDR_W`, 10: word address width; matches the data memory depth of 1024.
- `DATA_W`, 32: data word width.
- `MAX_BURST`, 4: maximum number of consecutive locked grants while the other port is waiting. Legal range is 2..15.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `pN_req`  in  1  port N requests an access this cycle (N = 0, 1).
- `pN_we`  in  1  1 = write, 0 = read.
- `pN_addr`  in  ADDR_W  word address.
- `pN_wdata`  in  DATA_W  write data.
- `pN_lock`  in  1  request to keep ownership after this access.
- `pN_gnt`  out  1  combinational; the access is performed this cycle.
- `pN_rvalid`  out  1  registered; read data valid.
- `pN_rdata`  out  DATA_W  registered read data.
- `mem_we`  out  1  to data memory write enable.
- `mem_addr`  out  ADDR_W  to data memory address.
- `mem_wdata`  out  DATA_W  to data memory write data.
- `mem_rdata`  in  DATA_W  from data memory read data (combinational).

## Operation
- **States:** IDLE, OWN0, OWN1.
- **Registers:**
  - `last_gnt`, 1 bit.
  - `burst_cnt`, 4 bits.
  - `holdoff[1:0]`: one-cycle mask.
- **Grants in IDLE:**
  - Eligible ports: `pN_req` is high and `holdoff[N]` is 0.
  - If exactly one port is eligible, that port is granted.
  - If both are eligible, the winner is set by the Configuration section.
- **Grants in OWNx:**
  - `px_gnt` = `px_req`.
  - The other port's grant is 0.
- **Datapath muxing:**
  - For the granted port: `mem_we` = `pN_we`, `mem_addr` = `pN_addr`, `mem_wdata` = `pN_wdata`.
  - With no grant, all three outputs are 0.
  - `p0_gnt` and `p1_gnt` are never high together.
- **Transitions from IDLE:**
  - A grant with `pN_lock` = 1 goes to OWNN with `burst_cnt` = 1.
  - A grant without lock stays in IDLE.
- **Transitions from OWNx:**
  - If `px_req` = 0 or `px_lock` = 0: go to IDLE. When the grant is taken with lock low, that access is still performed.
  - Else if `burst_cnt` = `MAX_BURST` and the other port requests: forced release. Go to IDLE, set `holdoff[x]` = 1, and deny the owner that cycle.
  - Else: stay in OWNx and increment `burst_cnt` on each grant. The count saturates at `MAX_BURST`.
- **Holdoff:** `holdoff` clears after exactly one cycle in IDLE.
- **`last_gnt`:** updated to N on every grant to port N.
- **Reads:** on a granted read, `pN_rdata` <= `mem_rdata` and `pN_rvalid` <= 1 at that edge. `pN_rvalid` is 0 in every other cycle. `pN_rdata` holds its value otherwise.
- **Writes:** no response; the write completes at the grant-cycle edge.

## Timing
- **Write:** the memory is written at the rising edge ending the grant cycle. Latency is 0 cycles after the grant.
- **Read:** `pN_rvalid`/`pN_rdata` appear 1 cycle after the grant cycle.
- **Throughput:** one access per cycle in total.
- **Reset (asynchronous, immediate):**
  - State = IDLE, `last_gnt` = 1, `burst_cnt` = 0, `holdoff` = 0.
  - `pN_rvalid` = 0, `pN_rdata` = 0.
  - While `rst_n` = 0: `pN_gnt` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- **Reset mid-burst:** drops ownership and any pending `rvalid` immediately. The first cycle after release re-arbitrates from IDLE.
- **Requester rule:** `pN_req` and its qualifiers must be held stable until `pN_gnt` is seen high.

## Configuration
- **`DMEM_ARB_RR_EN` defined:** round-robin. On a tie in IDLE, the winner is the port opposite `last_gnt`. Because `last_gnt` resets to 1, port 0 wins the first tie after reset.
- **`DMEM_ARB_RR_EN` undefined:** fixed priority. Port 0 always wins ties in IDLE. `last_gnt` is still maintained. The `holdoff` mechanism is what lets port 1 through after a port-0 forced release.

## Test plan
1. **Port 1 write/read:** reset, then port 1 writes 0xDEADBEEF to address 0x005, then port 1 reads address 0x005 -> `p1_gnt` high both cycles; `p1_rvalid` = 1 with `p1_rdata` = 0xDEADBEEF in the cycle after the read grant; `p0_rvalid` stays 0.
2. **Tie:** both ports request reads in the same cycle for 3 cycles, lock = 0 -> fixed mode: port 0 granted 3 times. `DMEM_ARB_RR_EN`: grants alternate 0, 1, 0.
3. **Burst limit:** port 0 locks and requests continuously, port 1 requests from cycle 1, `MAX_BURST` = 4 -> port 0 gets 4 grants, one cycle with no grant, port 1 granted the next cycle (holdoff), then port 0 regains.
4. **Early unlock:** port 1 locks for 2 grants then drops `p1_lock` on its 3rd access -> the 3rd access is performed; return to IDLE; port 0, waiting, is granted the next cycle.
5. **Async reset:** assert `rst_n` = 0 between edges during an OWN0 read burst -> all grants and `mem_we` drop to 0 immediately; `p0_rvalid` = 0; after release, state is IDLE and the first tie goes to port 0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundle of the two requester ports and the data-memory port of the
//   data-memory arbiter.
//
//   Port N (N = 0 CPU load/store, N = 1 loader/debug):
//     pN_req, pN_we, pN_addr, pN_wdata, pN_lock  requester -> arbiter
//     pN_gnt (combinational), pN_rvalid, pN_rdata (registered)
//                                                 arbiter -> requester
//   Memory side:
//     mem_we, mem_addr, mem_wdata                 arbiter -> memory
//     mem_rdata (combinational read)              memory  -> arbiter
//
//   Modports: slave = the arbiter, master = the requesters plus memory.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_lock;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_lock;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_lock,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_lock,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares a single-port data memory (combinational read, write on the rising
//   edge) between the CPU load/store path (port 0) and a loader/debug master
//   (port 1). A port may lock the memory for a burst; once the burst reaches
//   MAX_BURST grants while the other port waits, ownership is forcibly
//   released and the former owner is masked for one arbitration cycle.
//
//   Ports:
//     clk    clock, all state updates on the rising edge
//     rst_n  asynchronous active-low reset
//     bus    dmem_arbiter_if.slave (requester ports + memory port)
//
//   Parameters:
//     ADDR_W     word address width (must match the interface)
//     DATA_W     data width (must match the interface)
//     MAX_BURST  locked grants allowed while the other port waits, 2..15
//
//   Build option:
//     DMEM_ARB_RR_EN  defined   -> ties in IDLE go to the port opposite last_gnt
//                     undefined -> ties in IDLE go to port 0
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  state_t            state;
  logic              last_gnt;
  logic [3:0]        burst_cnt;
  logic [1:0]        holdoff;
  logic [1:0]        rvalid;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  logic [1:0]        req;
  logic [1:0]        we;
  logic [1:0]        lock;
  logic [1:0]        eligible;
  logic [1:0]        gnt;
  logic              owner;
  logic              tie_pick1;
  logic              forced_release;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  assign req      = {bus.p1_req,  bus.p0_req};
  assign we       = {bus.p1_we,   bus.p0_we};
  assign lock     = {bus.p1_lock, bus.p0_lock};
  assign eligible = req & ~holdoff;

  // Index of the owning port; only meaningful in OWN0/OWN1.
  assign owner = (state == OWN1);

`ifdef DMEM_ARB_RR_EN
  assign tie_pick1 = ~last_gnt;
`else
  // last_gnt is still tracked but has no say in fixed priority.
  assign tie_pick1 = last_gnt & 1'b0;
`endif

  // The owner is denied for one cycle when it wants to continue past the
  // burst limit while the other port is waiting.
  assign forced_release = req[owner] & lock[owner] &
                          (burst_cnt == BURST_LIMIT) & req[~owner];

  // NOTE: every output of a combinational block gets a default first, so no
  //       path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt = '0;
    case (state)
      IDLE:       gnt = (eligible == 2'b11) ? (tie_pick1 ? 2'b10 : 2'b01)
                                            : eligible;
      OWN0, OWN1: if (req[owner] && !forced_release)
                    gnt = owner ? 2'b10 : 2'b01;
      default:    gnt = '0;
    endcase
    // Grants must vanish the moment reset asserts, not at the next edge.
    if (!rst_n) gnt = '0;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[0]) begin
      mem_we    = bus.p0_we;
      mem_addr  = bus.p0_addr;
      mem_wdata = bus.p0_wdata;
    end else if (gnt[1]) begin
      mem_we    = bus.p1_we;
      mem_addr  = bus.p1_addr;
      mem_wdata = bus.p1_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  //       samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      burst_cnt <= 4'd0;
      holdoff   <= 2'b00;
      rvalid    <= 2'b00;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      rvalid <= gnt & ~we;
      if (gnt[0] && !we[0]) rdata0 <= bus.mem_rdata;
      if (gnt[1] && !we[1]) rdata1 <= bus.mem_rdata;

      if (gnt[0])      last_gnt <= 1'b0;
      else if (gnt[1]) last_gnt <= 1'b1;

      case (state)
        IDLE: begin
          // The holdoff mask only ever covers one arbitration cycle.
          holdoff <= 2'b00;
          if (gnt[0] && lock[0]) begin
            state     <= OWN0;
            burst_cnt <= 4'd1;
          end else if (gnt[1] && lock[1]) begin
            state     <= OWN1;
            burst_cnt <= 4'd1;
          end
        end
        OWN0, OWN1: begin
          if (!req[owner] || !lock[owner]) begin
            state <= IDLE;
          end else if (forced_release) begin
            state          <= IDLE;
            holdoff[owner] <= 1'b1;
          end else if (burst_cnt != BURST_LIMIT) begin
            // Saturates at the limit while the other port stays quiet.
            burst_cnt <= burst_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.p0_gnt    = gnt[0];
  assign bus.p1_gnt    = gnt[1];
  assign bus.p0_rvalid = rvalid[0];
  assign bus.p1_rvalid = rvalid[1];
  assign bus.p0_rdata  = rdata0;
  assign bus.p1_rdata  = rdata1;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter. Holds the data memory, drives both
//   requester ports and compares every cycle against a behavioural model of
//   the arbitration rules, then finishes with directed scenarios and a
//   randomized phase.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;

  logic clk;
  logic rst_n;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Data memory: combinational read, write on the rising edge.
  logic [DATA_W-1:0] mem [1<<ADDR_W];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: who owns the memory, how long the current burst is,
  // which port sits out the next arbitration, and the expected responses.
  int                m_owner;
  int                m_burst;
  int                m_last;
  bit                m_hold [2];
  bit                exp_rv [2];
  logic [DATA_W-1:0] exp_rd [2];
  logic [DATA_W-1:0] ref_mem [1<<ADDR_W];
  int                obs_g;
  int                last_g;

  task automatic model_reset();
    m_owner = -1;
    m_burst = 0;
    m_last  = 1;
    m_hold  = '{0, 0};
    exp_rv  = '{0, 0};
    exp_rd  = '{'0, '0};
  endtask

  task automatic drive(input int p, input bit req, input bit we,
                       input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] wd,
                       input bit lk);
    if (p == 0) begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = ad;
      bus.p0_wdata = wd; bus.p0_lock = lk;
    end else begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = ad;
      bus.p1_wdata = wd; bus.p1_lock = lk;
    end
  endtask

  task automatic idle_both();
    drive(0, 0, 0, '0, '0, 0);
    drive(1, 0, 0, '0, '0, 0);
  endtask

  // One clock cycle: compare at the falling edge, advance the model, then
  // return just after the rising edge ready for new stimulus.
  task automatic cycle();
    bit                req [2];
    bit                we  [2];
    bit                lk  [2];
    logic [ADDR_W-1:0] ad  [2];
    logic [DATA_W-1:0] wd  [2];
    bit                e0, e1, forced;
    int                g, o;
    @(negedge clk);
    req = '{bus.p0_req,  bus.p1_req};
    we  = '{bus.p0_we,   bus.p1_we};
    lk  = '{bus.p0_lock, bus.p1_lock};
    ad  = '{bus.p0_addr, bus.p1_addr};
    wd  = '{bus.p0_wdata, bus.p1_wdata};
    g = -1;
    forced = 0;
    o = m_owner;
    if (m_owner < 0) begin
      e0 = req[0] && !m_hold[0];
      e1 = req[1] && !m_hold[1];
      if (e0 && e1) begin
`ifdef DMEM_ARB_RR_EN
        g = 1 - m_last;
`else
        g = 0;
`endif
      end else if (e0) g = 0;
      else if (e1)     g = 1;
    end else begin
      if (req[o] && lk[o] && m_burst == MAX_BURST && req[1-o]) forced = 1;
      else if (req[o]) g = o;
    end

    obs_g = bus.p0_gnt ? 0 : (bus.p1_gnt ? 1 : -1);
    check("p0_gnt",    32'(bus.p0_gnt),    32'(g == 0));
    check("p1_gnt",    32'(bus.p1_gnt),    32'(g == 1));
    check("mem_we",    32'(bus.mem_we),    (g >= 0) ? 32'(we[g]) : 32'd0);
    check("mem_addr",  32'(bus.mem_addr),  (g >= 0) ? 32'(ad[g]) : 32'd0);
    check("mem_wdata", bus.mem_wdata,      (g >= 0) ? wd[g]       : 32'd0);
    check("p0_rvalid", 32'(bus.p0_rvalid), 32'(exp_rv[0]));
    check("p1_rvalid", 32'(bus.p1_rvalid), 32'(exp_rv[1]));
    check("p0_rdata",  bus.p0_rdata,       exp_rd[0]);
    check("p1_rdata",  bus.p1_rdata,       exp_rd[1]);

    for (int p = 0; p < 2; p++) begin
      exp_rv[p] = (g == p) && !we[p];
      if (exp_rv[p]) exp_rd[p] = ref_mem[ad[p]];
    end
    if (g >= 0) begin
      m_last = g;
      if (we[g]) ref_mem[ad[g]] = wd[g];
    end
    if (m_owner < 0) begin
      m_hold = '{0, 0};
      if (g >= 0 && lk[g]) begin
        m_owner = g;
        m_burst = 1;
      end
    end else if (!req[o] || !lk[o]) begin
      m_owner = -1;
    end else if (forced) begin
      m_owner   = -1;
      m_hold[o] = 1;
    end else if (m_burst < MAX_BURST) begin
      m_burst++;
    end
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  int exp2 [3];
  int exp3 [8] = '{0, 0, 0, 0, -1, 1, 0, 0};
  int exp4 [4] = '{1, 1, 1, 0};
  int n0;
  bit                pend [2];
  bit                r_we [2];
  bit                r_lk [2];
  logic [ADDR_W-1:0] r_ad [2];
  logic [DATA_W-1:0] r_wd [2];

  initial begin
    // Reset with requests already raised: nothing may reach the memory.
    rst_n = 1'b0;
    drive(0, 1, 1, 10'h3, 32'h1234_5678, 1);
    drive(1, 1, 0, 10'h9, 32'h0, 0);
    model_reset();
    #2;
    check("rst_p0_gnt",    32'(bus.p0_gnt),    32'd0);
    check("rst_p1_gnt",    32'(bus.p1_gnt),    32'd0);
    check("rst_mem_we",    32'(bus.mem_we),    32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("rst_mem_wdata", bus.mem_wdata,      32'd0);
    check("rst_p0_rvalid", 32'(bus.p0_rvalid), 32'd0);
    check("rst_p1_rvalid", 32'(bus.p1_rvalid), 32'd0);
    check("rst_p0_rdata",  bus.p0_rdata,       32'd0);
    check("rst_p1_rdata",  bus.p1_rdata,       32'd0);
    @(posedge clk);
    #1;
    idle_both();
    rst_n = 1'b1;

    // Port 1 write then read back.
    drive(1, 1, 1, 10'h005, 32'hDEAD_BEEF, 0);
    cycle();
    check("t1_wr_gnt", 32'(obs_g), 32'd1);
    drive(1, 1, 0, 10'h005, 32'h0, 0);
    cycle();
    check("t1_rd_gnt", 32'(obs_g), 32'd1);
    idle_both();
    check("t1_p1_rvalid", 32'(bus.p1_rvalid), 32'd1);
    check("t1_p1_rdata",  bus.p1_rdata,       32'hDEAD_BEEF);
    check("t1_p0_rvalid", 32'(bus.p0_rvalid), 32'd0);
    cycle();

    // Fill the addresses used below through port 1, leaving last_gnt = 1.
    for (int a = 0; a < 16; a++) begin
      drive(1, 1, 1, 10'(a), $urandom, 0);
      cycle();
    end
    idle_both();

    // Tie for three cycles, no lock.
`ifdef DMEM_ARB_RR_EN
    exp2 = '{0, 1, 0};
`else
    exp2 = '{0, 0, 0};
`endif
    n0 = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 10'(i), '0, 0);
      drive(1, 1, 0, 10'(i + 8), '0, 0);
      cycle();
      check("t2_tie_seq", 32'(obs_g), 32'(exp2[i]));
      if (obs_g == 0) n0++;
    end
`ifdef DMEM_ARB_RR_EN
    check("t2_p0_count", 32'(n0), 32'd2);
`else
    check("t2_p0_count", 32'(n0), 32'd3);
`endif
    drive(0, 0, 0, '0, '0, 0);
    cycle();
    check("t2_p1_late", 32'(obs_g), 32'd1);
    idle_both();
    cycle();

    // Burst limit with port 1 waiting from the second cycle.
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 1, 10'(i + 1), $urandom, 1);
      drive(1, (i >= 1 && i <= 5), 0, 10'h7, '0, 0);
      cycle();
      check("t3_burst_seq", 32'(obs_g), 32'(exp3[i]));
    end
    drive(0, 1, 0, 10'h2, '0, 0);
    drive(1, 0, 0, '0, '0, 0);
    cycle();
    idle_both();
    cycle();

    // Port 1 locks twice and drops lock on its third access.
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1, 1, 0, 10'(10 + i), '0, (i < 2));
      else       drive(1, 0, 0, '0, '0, 0);
      if (i >= 1) drive(0, 1, 0, 10'h3, '0, 0);
      cycle();
      check("t4_unlock_seq", 32'(obs_g), 32'(exp4[i]));
    end
    idle_both();
    cycle();

    // Asynchronous reset in the middle of a locked port-0 read burst.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 10'(i + 1), '0, 1);
      cycle();
      check("t5_burst_gnt", 32'(obs_g), 32'd0);
    end
    check("t5_pre_rvalid", 32'(bus.p0_rvalid), 32'd1);
    check("t5_pre_rdata",  bus.p0_rdata,       exp_rd[0]);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_p0_gnt",    32'(bus.p0_gnt),    32'd0);
    check("t5_rst_p1_gnt",    32'(bus.p1_gnt),    32'd0);
    check("t5_rst_mem_we",    32'(bus.mem_we),    32'd0);
    check("t5_rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("t5_rst_p0_rvalid", 32'(bus.p0_rvalid), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 1, 0, 10'h4, '0, 0);
    drive(1, 1, 0, 10'hC, '0, 0);
    cycle();
    check("t5_first_tie", 32'(obs_g), 32'd0);
    drive(0, 0, 0, '0, '0, 0);
    cycle();
    check("t5_p1_after", 32'(obs_g), 32'd1);
    idle_both();
    cycle();

    // Randomized traffic; requests stay stable until granted.
    pend = '{0, 0};
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 99) < 85) begin
          pend[p] = 1;
          r_we[p] = 1'($urandom_range(0, 1));
          r_ad[p] = 10'($urandom_range(0, 15));
          r_wd[p] = $urandom;
          r_lk[p] = ($urandom_range(0, 3) != 0);
        end
        drive(p, pend[p], r_we[p], r_ad[p], r_wd[p], r_lk[p]);
      end
      cycle();
      if (last_g >= 0) pend[last_g] = 0;
    end
    idle_both();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
